// File: rtl/cv32e40x_pkg.sv
// Shared LSU types: transfer size, per-request attributes, buffered response entry,
// and the load-data alignment/extension helper.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } lsu_size_e;

  typedef struct packed {
    lsu_size_e   size;
    logic        sext;
    logic [1:0]  offset;
  } lsu_resp_attr_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } lsu_resp_t;

  // Reserved size encoding 2'b11 passes data through like WORD.
  function automatic logic [31:0] lsu_format_rdata(input lsu_resp_attr_t attr,
                                                   input logic [31:0]    rdata);
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_res;
    w_half = attr.offset[1] ? rdata[31:16] : rdata[15:0];
    case (attr.offset)
      2'b00:   w_byte = rdata[7:0];
      2'b01:   w_byte = rdata[15:8];
      2'b10:   w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    case (attr.size)
      BYTE:    w_res = {{24{attr.sext & w_byte[7]}}, w_byte};
      HALF:    w_res = {{16{attr.sext & w_half[15]}}, w_half};
      default: w_res = rdata;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/cv32e40x_lsu_resp_fifo.sv
// Generic synchronous FIFO, sync active-high reset; full detected via an extra pointer bit.
module cv32e40x_lsu_resp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_mem [1 << AW];
  logic [AW-1:0]    w_widx;
  logic [AW-1:0]    w_ridx;
  logic [PW-1:0]    w_used;
  logic             w_do_push;
  logic             w_do_pop;

  generate
    if (DEPTH == 1) begin : g_single
      assign w_widx = '0;
      assign w_ridx = '0;
    end else begin : g_multi
      assign w_widx = r_wptr[AW-1:0];
      assign w_ridx = r_rptr[AW-1:0];
    end
  endgenerate

  assign w_used    = r_wptr - r_rptr;
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (w_used == PW'(DEPTH));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[w_ridx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[w_widx] <= i_wdata;
  end

endmodule

// File: rtl/cv32e40x_lsu_resp_buffer.sv
// LSU response buffer: tracks issued OBI requests, formats load data, hands it to writeback.
// Optional same-cycle bypass when CV32E40X_LSU_RESP_BYPASS_EN is defined.
module cv32e40x_lsu_resp_buffer
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [1:0]               req_size_i,
  input  logic                     req_sext_i,
  input  logic [1:0]               req_offset_i,
  input  logic                     data_rvalid_i,
  input  logic [31:0]              data_rdata_i,
  input  logic                     data_err_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [31:0]              resp_rdata_o,
  output logic                     resp_err_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     busy_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]  r_cnt;
  lsu_resp_attr_t w_attr_in;
  lsu_resp_attr_t w_attr_head;
  logic           w_attr_empty;
  logic           w_attr_full;
  lsu_resp_t      w_rsp_in;
  lsu_resp_t      w_rsp_head;
  logic           w_rsp_empty;
  logic           w_rsp_full;
  logic           w_req_acc;
  logic           w_rvalid;
  logic           w_rsp_push;
  logic           w_rsp_pop;
  logic           w_resp_hs;

  assign req_ready_o = (r_cnt < CW'(DEPTH));
  assign w_req_acc   = req_valid_i && req_ready_o;
  // Responses with no matching attribute entry (e.g. after reset) are dropped here.
  assign w_rvalid    = data_rvalid_i && !w_attr_empty;

  assign w_attr_in.size   = lsu_size_e'(req_size_i);
  assign w_attr_in.sext   = req_sext_i;
  assign w_attr_in.offset = req_offset_i;

  assign w_rsp_in.rdata = lsu_format_rdata(w_attr_head, data_rdata_i);
  assign w_rsp_in.err   = data_err_i;

  cv32e40x_lsu_resp_fifo #(
    .WIDTH ($bits(lsu_resp_attr_t)),
    .DEPTH (DEPTH)
  ) u_attr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_req_acc),
    .i_wdata (w_attr_in),
    .i_pop   (w_rvalid),
    .o_rdata (w_attr_head),
    .o_empty (w_attr_empty),
    .o_full  (w_attr_full)
  );

  cv32e40x_lsu_resp_fifo #(
    .WIDTH ($bits(lsu_resp_t)),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rsp_push),
    .i_wdata (w_rsp_in),
    .i_pop   (w_rsp_pop),
    .o_rdata (w_rsp_head),
    .o_empty (w_rsp_empty),
    .o_full  (w_rsp_full)
  );

`ifdef CV32E40X_LSU_RESP_BYPASS_EN
  logic w_byp;
  assign w_byp        = w_rsp_empty && w_rvalid;
  assign resp_valid_o = !w_rsp_empty || w_byp;
  assign resp_rdata_o = w_byp ? w_rsp_in.rdata : (w_rsp_empty ? '0 : w_rsp_head.rdata);
  assign resp_err_o   = w_byp ? w_rsp_in.err   : (!w_rsp_empty && w_rsp_head.err);
  assign w_rsp_push   = w_rvalid && !(w_byp && resp_ready_i);
  assign w_rsp_pop    = !w_rsp_empty && resp_ready_i;
`else
  assign resp_valid_o = !w_rsp_empty;
  assign resp_rdata_o = w_rsp_empty ? '0 : w_rsp_head.rdata;
  assign resp_err_o   = !w_rsp_empty && w_rsp_head.err;
  assign w_rsp_push   = w_rvalid;
  assign w_rsp_pop    = !w_rsp_empty && resp_ready_i;
`endif

  assign w_resp_hs = resp_valid_o && resp_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case ({w_req_acc, w_resp_hs})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign cnt_o  = r_cnt;
  assign busy_o = (r_cnt != '0);

  a_req_when_full: assert property (@(posedge clk) disable iff (rst)
    !(req_valid_i && !req_ready_o))
    else $warning("request while not ready ignored");

  a_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(data_rvalid_i && w_attr_empty))
    else $warning("rvalid without outstanding request ignored");

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !((w_req_acc && w_attr_full) || (w_rsp_push && w_rsp_full)));

endmodule

// File: tb/tb_cv32e40x_lsu_resp_buffer.sv
// Directed table-driven bench for cv32e40x_lsu_resp_buffer (default, non-bypass build).
module tb_cv32e40x_lsu_resp_buffer;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_size_i;
  logic        req_sext_i;
  logic [1:0]  req_offset_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [1:0]  cnt_o;
  logic        busy_o;

  int unsigned n_cmp;
  int unsigned n_bad;

  typedef struct {
    logic [1:0]  size;
    logic        sext;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  cv32e40x_lsu_resp_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_size_i    (req_size_i),
    .req_sext_i    (req_sext_i),
    .req_offset_i  (req_offset_i),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .data_err_i    (data_err_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_rdata_o  (resp_rdata_o),
    .resp_err_o    (resp_err_o),
    .cnt_o         (cnt_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] size, input logic sext, input logic [1:0] off);
    req_valid_i  = 1'b1;
    req_size_i   = size;
    req_sext_i   = sext;
    req_offset_i = off;
    tick();
    req_valid_i  = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata, input logic err);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    data_err_i    = err;
    tick();
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    req_valid_i = 1'b0; req_size_i = 2'b00; req_sext_i = 1'b0; req_offset_i = 2'b00;
    data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0; resp_ready_i = 1'b0;

    vecs[0]  = '{2'b00, 1'b1, 2'd2, 32'h1280_3456, 1'b0, 32'hFFFF_FF80};
    vecs[1]  = '{2'b01, 1'b0, 2'd3, 32'hBEEF_1234, 1'b0, 32'h0000_BEEF};
    vecs[2]  = '{2'b10, 1'b0, 2'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{2'b10, 1'b1, 2'd1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
    vecs[4]  = '{2'b00, 1'b0, 2'd0, 32'h0000_00F7, 1'b0, 32'h0000_00F7};
    vecs[5]  = '{2'b00, 1'b1, 2'd1, 32'h0000_7F00, 1'b0, 32'h0000_007F};
    vecs[6]  = '{2'b00, 1'b1, 2'd3, 32'hA500_0000, 1'b0, 32'hFFFF_FFA5};
    vecs[7]  = '{2'b01, 1'b1, 2'd0, 32'h0001_8001, 1'b0, 32'hFFFF_8001};
    vecs[8]  = '{2'b01, 1'b1, 2'd2, 32'h7FFF_0000, 1'b0, 32'h0000_7FFF};
    vecs[9]  = '{2'b01, 1'b0, 2'd1, 32'h0000_ABCD, 1'b0, 32'h0000_ABCD};
    vecs[10] = '{2'b00, 1'b0, 2'd3, 32'hFF00_0000, 1'b0, 32'h0000_00FF};

    tick(); tick();
    rst = 1'b0;
    chk("rst_cnt",   32'(cnt_o), 32'd0);
    chk("rst_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'h0);
    chk("rst_err",   32'(resp_err_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_busy",  32'(busy_o), 32'd0);

    // single-load vectors, writeback always ready
    resp_ready_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].size, vecs[i].sext, vecs[i].off);
      chk($sformatf("v%0d_cnt_up", i), 32'(cnt_o), 32'd1);
      chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'd1);
      respond(vecs[i].rdata, vecs[i].err);
      chk($sformatf("v%0d_valid", i), 32'(resp_valid_o), 32'd1);
      chk($sformatf("v%0d_rdata", i), resp_rdata_o, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(resp_err_o), 32'(vecs[i].err));
      tick();
      chk($sformatf("v%0d_drained", i), 32'(resp_valid_o), 32'd0);
      chk($sformatf("v%0d_cnt_down", i), 32'(cnt_o), 32'd0);
    end

    // backpressure: fill both slots, hold writeback off
    resp_ready_i = 1'b0;
    issue(2'b10, 1'b0, 2'd0);
    issue(2'b10, 1'b0, 2'd0);
    chk("bp_cnt2", 32'(cnt_o), 32'd2);
    chk("bp_req_ready0", 32'(req_ready_o), 32'd0);
    respond(32'h11, 1'b0);
    chk("bp_first", resp_rdata_o, 32'h11);
    respond(32'h22, 1'b0);
    chk("bp_hold1", resp_rdata_o, 32'h11);
    tick();
    chk("bp_hold2", resp_rdata_o, 32'h11);
    chk("bp_still_full", 32'(req_ready_o), 32'd0);
    resp_ready_i = 1'b1;
    tick();
    chk("bp_second", resp_rdata_o, 32'h22);
    chk("bp_cnt1", 32'(cnt_o), 32'd1);
    chk("bp_req_ready1", 32'(req_ready_o), 32'd1);
    tick();
    chk("bp_empty", 32'(resp_valid_o), 32'd0);
    chk("bp_cnt0", 32'(cnt_o), 32'd0);

    // accept a request in the same cycle as a response handshake
    resp_ready_i = 1'b0;
    issue(2'b00, 1'b0, 2'd0);
    respond(32'h0000_00AB, 1'b0);
    chk("sim_a", resp_rdata_o, 32'h0000_00AB);
    chk("sim_cnt_pre", 32'(cnt_o), 32'd1);
    resp_ready_i = 1'b1;
    issue(2'b01, 1'b0, 2'd2);
    chk("sim_cnt_hold", 32'(cnt_o), 32'd1);
    chk("sim_popped", 32'(resp_valid_o), 32'd0);
    respond(32'h1234_0000, 1'b0);
    chk("sim_b_order", resp_rdata_o, 32'h0000_1234);
    tick();
    chk("sim_cnt0", 32'(cnt_o), 32'd0);

    // reset with two outstanding requests, then an orphan response
    resp_ready_i = 1'b0;
    issue(2'b10, 1'b0, 2'd0);
    issue(2'b10, 1'b0, 2'd0);
    respond(32'h5555_AAAA, 1'b1);
    chk("mr_cnt2", 32'(cnt_o), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_cnt0", 32'(cnt_o), 32'd0);
    chk("mr_valid0", 32'(resp_valid_o), 32'd0);
    chk("mr_err0", 32'(resp_err_o), 32'd0);
    chk("mr_ready1", 32'(req_ready_o), 32'd1);
    respond(32'h7777_7777, 1'b0);
    chk("orphan_valid", 32'(resp_valid_o), 32'd0);
    chk("orphan_cnt", 32'(cnt_o), 32'd0);
    chk("orphan_busy", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
